vp_matmul_system: RTL and testbench

Parametrised matrix-multiply engine for the vector processor SoC. It holds a matrix A (K columns of LANES elements) and a matrix B (NCOLS columns of K elements) in an internal word RAM loaded over a write port. On `start` it produces the NCOLS columns of C = A·B one at a time, each as a LANES-wide word tagged with its column index. This generation adds a configurable lane count, element width, inner dimension and column count, plus a `Busy` output and guarded writes and starts. At default parameters it matches the existing 16-lane, 32-bit, 7-clocks-per-column system interface.

---
 rtl/vp_pkg.sv | 25 ++
 rtl/vp_word_ram.sv | 29 ++
 rtl/vp_matmul_system.sv | 160 ++++++++++++++++
 tb/tb_vp_matmul_system.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vp_pkg.sv
// Shared state encoding and helpers for the vp_matmul_system engine.
`ifndef VP_PKG_SV
`define VP_PKG_SV

// Selects element idx of a packed lane word whose elements are ew bits wide.
`define VP_LANE(word, idx, ew) word[(idx)*(ew) +: (ew)]

package vp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RDB,
        ST_LDB,
        ST_MAC,
        ST_OUT
    } vp_state_e;

    // Counter width that stays legal when the counted range is a single value.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`endif

// File: rtl/vp_word_ram.sv
// Single-port word RAM: one write port, synchronous read with one cycle of latency.
module vp_word_ram
    import vp_pkg::*;
#(
    parameter  int DEPTH = 20,
    parameter  int WIDTH = 512,
    localparam int AW    = idx_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Contents survive reset on purpose, so no reset branch here.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/vp_matmul_system.sv
// Matrix-multiply engine: streams the columns of C = A*B out of a shared word RAM,
// one LANES-wide result word per K+3 clocks.
module vp_matmul_system
    import vp_pkg::*;
#(
    parameter  int LANES = 16,
    parameter  int EW    = 32,
    parameter  int K     = 4,
    parameter  int NCOLS = 16,
    localparam int AW    = $clog2(K + NCOLS),
    localparam int RW    = $clog2(NCOLS)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                WE,
    input  logic [AW-1:0]       InAddress,
    input  logic [LANES*EW-1:0] DataIn,
    input  logic                start,
    output logic [RW-1:0]       ResultAddress,
    output logic [LANES*EW-1:0] FinalDataOut,
    output logic                AnsValid,
    output logic                Busy
);

    localparam int          KW    = idx_width(K);
    localparam int          WIDTH = LANES * EW;
    localparam logic [AW:0] DEPTH = (AW + 1)'(K + NCOLS);

    vp_state_e        state_q, state_d;
    logic [RW-1:0]    j_q, j_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] coeff_q, coeff_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [RW-1:0]    res_addr_q, res_addr_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;

    logic [AW-1:0]    rd_addr;
    logic [AW-1:0]    ram_addr;
    logic             wr_ok;
    logic [WIDTH-1:0] ram_rdata;
    logic [EW-1:0]    b_coef;
    logic [WIDTH-1:0] mac_sum;

    // Writes win the port only while idle; while busy the FSM owns the read address.
    always_comb begin
        rd_addr = '0;
        case (state_q)
            ST_RDB:  rd_addr = AW'(K) + AW'(j_q);
            ST_MAC:  rd_addr = AW'(k_q) + 1'b1;
            default: rd_addr = '0;
        endcase
        wr_ok    = WE && !busy_q && ({1'b0, InAddress} < DEPTH);
        ram_addr = wr_ok ? InAddress : rd_addr;
    end

    vp_word_ram #(
        .DEPTH (K + NCOLS),
        .WIDTH (WIDTH)
    ) u_ram (
        .clk   (CLK),
        .we    (wr_ok),
        .addr  (ram_addr),
        .wdata (DataIn),
        .rdata (ram_rdata)
    );

    // One truncating multiply-accumulate per lane against B lane k.
    always_comb begin
        b_coef  = `VP_LANE(coeff_q, k_q, EW);
        mac_sum = '0;
        for (int r = 0; r < LANES; r++) begin
            `VP_LANE(mac_sum, r, EW) = `VP_LANE(acc_q, r, EW) + `VP_LANE(ram_rdata, r, EW) * b_coef;
        end
    end

    // The result is captured on the edge that enters OUT, so AnsValid and
    // FinalDataOut are both visible during the OUT cycle itself.
    always_comb begin
        state_d    = state_q;
        j_d        = j_q;
        k_d        = k_q;
        coeff_d    = coeff_q;
        acc_d      = acc_q;
        out_d      = out_q;
        res_addr_d = res_addr_q;
        valid_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RDB;
                    j_d     = '0;
                end
            end
            ST_RDB: begin
                state_d = ST_LDB;
            end
            ST_LDB: begin
                coeff_d = ram_rdata;
                acc_d   = '0;
                k_d     = '0;
                state_d = ST_MAC;
            end
            ST_MAC: begin
                acc_d = mac_sum;
                if (k_q == KW'(K - 1)) begin
                    state_d    = ST_OUT;
                    out_d      = mac_sum;
                    res_addr_d = j_q;
                    valid_d    = 1'b1;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_OUT: begin
                if (j_q == RW'(NCOLS - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    j_d     = j_q + 1'b1;
                    state_d = ST_RDB;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            j_q        <= '0;
            k_q        <= '0;
            coeff_q    <= '0;
            acc_q      <= '0;
            out_q      <= '0;
            res_addr_q <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            j_q        <= j_d;
            k_q        <= k_d;
            coeff_q    <= coeff_d;
            acc_q      <= acc_d;
            out_q      <= out_d;
            res_addr_q <= res_addr_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    assign ResultAddress = res_addr_q;
    assign FinalDataOut  = out_q;
    assign AnsValid      = valid_q;
    assign Busy          = busy_q;

endmodule

// File: tb/tb_vp_matmul_system.sv
// Randomised self-checking bench for vp_matmul_system against an array-based
// matrix model of A, B and C = A*B.
module tb_vp_matmul_system;

    localparam int LANES = 16;
    localparam int EW    = 32;
    localparam int K     = 4;
    localparam int NCOLS = 16;
    localparam int CPC   = K + 3;
    localparam int DEPTH = K + NCOLS;
    localparam int WIDTH = LANES * EW;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             WE;
    logic [4:0]       InAddress;
    logic [WIDTH-1:0] DataIn;
    logic             start;
    logic [3:0]       ResultAddress;
    logic [WIDTH-1:0] FinalDataOut;
    logic             AnsValid;
    logic             Busy;

    int unsigned      mem_model [DEPTH][LANES];
    int unsigned      word_buf  [LANES];
    logic [WIDTH-1:0] exp_col   [NCOLS];
    logic [WIDTH-1:0] cap_col   [NCOLS];
    int               checks   = 0;
    int               failures = 0;

    vp_matmul_system #(
        .LANES (LANES),
        .EW    (EW),
        .K     (K),
        .NCOLS (NCOLS)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .WE            (WE),
        .InAddress     (InAddress),
        .DataIn        (DataIn),
        .start         (start),
        .ResultAddress (ResultAddress),
        .FinalDataOut  (FinalDataOut),
        .AnsValid      (AnsValid),
        .Busy          (Busy)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [WIDTH-1:0] packWord();
        logic [WIDTH-1:0] w;
        w = '0;
        for (int r = 0; r < LANES; r++) begin
            w[r*EW +: EW] = word_buf[r];
        end
        return w;
    endfunction

    // Column j of C, lane r: sum over k of A[k][r] * B[j][k], wrapping at 32 bits.
    task automatic computeExpected();
        int unsigned sum;
        for (int j = 0; j < NCOLS; j++) begin
            for (int r = 0; r < LANES; r++) begin
                sum = 0;
                for (int k = 0; k < K; k++) begin
                    sum += mem_model[k][r] * mem_model[K + j][k];
                end
                exp_col[j][r*EW +: EW] = sum;
            end
        end
    endtask

    // Idle-time write of word_buf; the model only keeps in-range addresses.
    task automatic applyStimulus(input int addr);
        WE        = 1'b1;
        InAddress = addr[4:0];
        DataIn    = packWord();
        @(posedge CLK);
        #1;
        WE = 1'b0;
        if (addr < DEPTH) begin
            for (int r = 0; r < LANES; r++) begin
                mem_model[addr][r] = word_buf[r];
            end
        end
    endtask

    task automatic pulseReset(input string tag);
        RESET = 1'b1;
        #1;
        checkOutput({tag, "_rst_valid"}, AnsValid, '0);
        checkOutput({tag, "_rst_busy"}, Busy, '0);
        checkOutput({tag, "_rst_addr"}, ResultAddress, '0);
        checkOutput({tag, "_rst_data"}, FinalDataOut, '0);
        #1;
        RESET = 1'b0;
        start = 1'b0;
        WE    = 1'b0;
    endtask

    // Cycle c counts from the first cycle after the edge that samples start.
    task automatic runColumns(input string tag, input bit hold_start,
                              input bit write_during, input int abort_col);
        int  pulses;
        int  last;
        bit  exp_busy;
        computeExpected();
        start = 1'b1;
        @(posedge CLK);
        #1;
        if (!hold_start) start = 1'b0;
        pulses = 0;
        last   = NCOLS * CPC + 2;
        for (int c = 1; c <= last; c++) begin
            WE = write_during && (c == 3);
            if (WE) begin
                InAddress = '0;
                DataIn    = '0;
            end
            if (abort_col >= 0 && c == abort_col * CPC + 4) begin
                pulseReset({tag, "_abort"});
                checkOutput({tag, "_abort_pulses"}, pulses, abort_col);
                return;
            end
            exp_busy = (c <= NCOLS * CPC) || (hold_start && c == last);
            checkOutput({tag, "_busy"}, Busy, exp_busy);
            if (AnsValid) begin
                pulses++;
                checkOutput({tag, "_valid_cycle"}, c, pulses * CPC);
                checkOutput({tag, "_res_addr"}, ResultAddress, pulses - 1);
                if (pulses <= NCOLS) begin
                    cap_col[pulses-1] = FinalDataOut;
                    checkOutput({tag, "_col_data"}, FinalDataOut, exp_col[pulses-1]);
                end
            end else if (pulses > 0 && pulses <= NCOLS) begin
                checkOutput({tag, "_hold_data"}, FinalDataOut, exp_col[pulses-1]);
            end
            @(posedge CLK);
            #1;
        end
        start = 1'b0;
        WE    = 1'b0;
        checkOutput({tag, "_pulse_count"}, pulses, NCOLS);
    endtask

    initial begin
        RESET     = 1'b1;
        WE        = 1'b0;
        start     = 1'b0;
        InAddress = '0;
        DataIn    = '0;
        @(posedge CLK);
        #1;
        checkOutput("init_valid", AnsValid, '0);
        checkOutput("init_busy", Busy, '0);
        checkOutput("init_addr", ResultAddress, '0);
        checkOutput("init_data", FinalDataOut, '0);
        RESET = 1'b0;
        @(posedge CLK);
        #1;

        // A lanes = k+1, B lanes 0..3 = 1 with junk above: every lane sums to 10.
        for (int k = 0; k < K; k++) begin
            foreach (word_buf[r]) word_buf[r] = k + 1;
            applyStimulus(k);
        end
        for (int j = 0; j < NCOLS; j++) begin
            foreach (word_buf[r]) word_buf[r] = (r < K) ? 32'd1 : 32'hDEADBEEF;
            applyStimulus(K + j);
        end
        runColumns("ones", 1'b0, 1'b0, -1);
        checkOutput("ones_c0_l0", cap_col[0][31:0], 32'd10);
        checkOutput("ones_c15_l15", cap_col[15][15*EW +: EW], 32'd10);

        // All-ones A times 2 wraps to 0xFFFFFFF8.
        for (int k = 0; k < K; k++) begin
            foreach (word_buf[r]) word_buf[r] = 32'hFFFFFFFF;
            applyStimulus(k);
        end
        for (int j = 0; j < NCOLS; j++) begin
            foreach (word_buf[r]) word_buf[r] = (r < K) ? 32'd2 : $urandom;
            applyStimulus(K + j);
        end
        runColumns("wrap", 1'b0, 1'b0, -1);
        checkOutput("wrap_c3_l7", cap_col[3][7*EW +: EW], 32'hFFFFFFF8);

        // Held start plus a write while busy: the write is dropped, the restart waits for IDLE.
        runColumns("hold", 1'b1, 1'b1, -1);
        pulseReset("hold_end");
        @(posedge CLK);
        #1;

        // Out-of-range writes must not disturb any word.
        for (int a = DEPTH; a < 32; a++) begin
            foreach (word_buf[r]) word_buf[r] = $urandom;
            applyStimulus(a);
        end
        runColumns("oor", 1'b0, 1'b0, -1);

        // Random contents, abort in column 5, then a full rerun from retained RAM.
        for (int a = 0; a < DEPTH; a++) begin
            foreach (word_buf[r]) word_buf[r] = $urandom;
            applyStimulus(a);
        end
        runColumns("abort", 1'b0, 1'b0, 5);
        @(posedge CLK);
        #1;
        runColumns("rerun", 1'b0, 1'b0, -1);

        // A[k] lane r = r+k, B[j] lane k = j+1 gives C lane r = (j+1)(4r+6).
        for (int k = 0; k < K; k++) begin
            foreach (word_buf[r]) word_buf[r] = r + k;
            applyStimulus(k);
        end
        for (int j = 0; j < NCOLS; j++) begin
            foreach (word_buf[r]) word_buf[r] = (r < K) ? j + 1 : $urandom;
            applyStimulus(K + j);
        end
        runColumns("ramp", 1'b0, 1'b0, -1);
        for (int ji = 0; ji < 3; ji++) begin
            int j;
            j = (ji == 0) ? 0 : (ji == 1) ? 7 : 15;
            for (int r = 0; r < LANES; r += 5) begin
                checkOutput("ramp_formula", cap_col[j][r*EW +: EW], (j + 1) * (4 * r + 6));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
